// File: rtl/act_bin_packer.sv
// Binarizes a signed activation stream against THRESH and packs bits LSB-first
// into PACK_W-bit words, flushing at frame ends. Optional macro: BIN_POPCOUNT_EN.
module act_bin_packer #(
  parameter int unsigned DIN_W     = 32,
  parameter int unsigned PACK_W    = 32,
  parameter int          THRESH    = 0,
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIN_W-1:0]             din,
  input  logic                         ivalid,
  output logic                         iready,
  output logic [PACK_W-1:0]            dout,
  output logic                         ovalid,
  input  logic                         oready,
  output logic [$clog2(PACK_W+1)-1:0]  obits,
  output logic                         olast
`ifdef BIN_POPCOUNT_EN
  ,
  output logic [$clog2(PACK_W+1)-1:0]  opop
`endif
);

  localparam int unsigned BW = $clog2(PACK_W + 1);
  localparam int unsigned CW = $clog2(PACK_W);
  localparam int unsigned FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic signed [DIN_W-1:0] THR = DIN_W'(THRESH);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [PACK_W-1:0] acc_q, acc_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [PACK_W-1:0] dout_q, dout_d;
  logic [BW-1:0]     obits_q, obits_d;
  logic              olast_q, olast_d;

  logic              accept;
  logic              bit_in;
  logic              word_end;
  logic              frame_end;
  logic              complete;
  logic [PACK_W-1:0] merged;

  // A held output word blocks the input side.
  assign iready = !((state_q == FULL) && !oready);
  assign ovalid = (state_q == FULL);
  assign dout   = dout_q;
  assign obits  = obits_q;
  assign olast  = olast_q;

  // Binarize the incoming beat and form the word as it would be flushed now.
  always_comb begin
    bit_in    = ($signed(din) > THR);
    accept    = ivalid && iready;
    word_end  = (bcnt_q == CW'(PACK_W - 1));
    frame_end = (fcnt_q == FW'(FRAME_LEN - 1));
    complete  = accept && (word_end || frame_end);
    merged    = acc_q;
    merged[bcnt_q] = bit_in;
    for (int i = 0; i < PACK_W; i++) begin
      if (CW'(i) > bcnt_q) merged[i] = 1'b0;
    end
  end

  // Next-state: accumulator, counters, output word and FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bcnt_d  = bcnt_q;
    fcnt_d  = fcnt_q;
    dout_d  = dout_q;
    obits_d = obits_q;
    olast_d = olast_q;

    if (accept) begin
      if (complete) begin
        acc_d   = '0;
        bcnt_d  = '0;
        fcnt_d  = frame_end ? '0 : fcnt_q + FW'(1);
        dout_d  = merged;
        obits_d = BW'(bcnt_q) + BW'(1);
        olast_d = frame_end;
      end else begin
        acc_d  = merged;
        bcnt_d = bcnt_q + CW'(1);
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    case (state_q)
      EMPTY: if (complete) state_d = FULL;
      FULL:  if (oready && !complete) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      bcnt_q  <= '0;
      fcnt_q  <= '0;
      dout_q  <= '0;
      obits_q <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
      dout_q  <= dout_d;
      obits_q <= obits_d;
      olast_q <= olast_d;
    end
  end

`ifdef BIN_POPCOUNT_EN
  logic [BW-1:0] pop_q, pop_d;

  // Popcount registered alongside dout so it carries no extra latency.
  always_comb begin
    pop_d = pop_q;
    if (complete) begin
      pop_d = '0;
      for (int i = 0; i < PACK_W; i++) pop_d = pop_d + BW'(merged[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pop_q <= '0;
    else     pop_q <= pop_d;
  end

  assign opop = pop_q;
`endif

endmodule

// File: tb/tb_act_bin_packer.sv
// Directed self-checking bench for act_bin_packer (default and FRAME_LEN=40 instances).
module tb_act_bin_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid;
  logic        oready;
  logic [31:0] din;

  logic        a_iready, a_ovalid, a_olast;
  logic [31:0] a_dout;
  logic [5:0]  a_obits;
  logic        b_iready, b_ovalid, b_olast;
  logic [31:0] b_dout;
  logic [5:0]  b_obits;
`ifdef BIN_POPCOUNT_EN
  logic [5:0]  a_opop, b_opop;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  act_bin_packer u_dut_a (
    .clk(clk), .rst(rst), .din(din), .ivalid(ivalid), .iready(a_iready),
    .dout(a_dout), .ovalid(a_ovalid), .oready(oready), .obits(a_obits), .olast(a_olast)
`ifdef BIN_POPCOUNT_EN
    , .opop(a_opop)
`endif
  );

  act_bin_packer #(.FRAME_LEN(40)) u_dut_b (
    .clk(clk), .rst(rst), .din(din), .ivalid(ivalid), .iready(b_iready),
    .dout(b_dout), .ovalid(b_ovalid), .oready(oready), .obits(b_obits), .olast(b_olast)
`ifdef BIN_POPCOUNT_EN
    , .opop(b_opop)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    ivalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    din    = d;
    ivalid = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst    = 1'b1;
    ivalid = 1'b0;
    oready = 1'b1;
    din    = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset values
    check("rst_dout",   64'(a_dout),   64'h0);
    check("rst_obits",  64'(a_obits),  64'h0);
    check("rst_olast",  64'(a_olast),  64'h0);
    check("rst_ovalid", 64'(a_ovalid), 64'h0);
    check("rst_iready", 64'(a_iready), 64'h1);

    // alternating +5/-3 over one 64-beat frame
    oready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      beat((k % 2 == 0) ? 32'd5 : 32'hFFFF_FFFD);
      if (k == 30 || k == 32) check("t1_no_valid", 64'(a_ovalid), 64'h0);
      if (k == 31 || k == 63) begin
        check("t1_ovalid", 64'(a_ovalid), 64'h1);
        check("t1_dout",   64'(a_dout),   64'h5555_5555);
        check("t1_obits",  64'(a_obits),  64'd32);
        check("t1_olast",  64'(a_olast),  (k == 63) ? 64'h1 : 64'h0);
`ifdef BIN_POPCOUNT_EN
        check("t1_opop",   64'(a_opop),   64'd16);
`endif
      end
    end
    ivalid = 1'b0;
    @(posedge clk); #1;
    check("t1_drain", 64'(a_ovalid), 64'h0);

    // signed compare corner values
    do_reset();
    beat(32'h0000_0000);
    beat(32'h0000_0001);
    beat(32'hFFFF_FFFF);
    beat(32'h7FFF_FFFF);
    beat(32'h8000_0000);
    for (int k = 0; k < 27; k++) beat(32'h0);
    check("t2_ovalid", 64'(a_ovalid), 64'h1);
    check("t2_dout",   64'(a_dout),   64'h0000_000A);
    check("t2_olast",  64'(a_olast),  64'h0);
    ivalid = 1'b0;

    // FRAME_LEN=40: full word then 8-bit partial with olast
    do_reset();
    for (int k = 0; k < 40; k++) begin
      beat(32'd1);
      if (k == 31) begin
        check("t3_w1_ovalid", 64'(b_ovalid), 64'h1);
        check("t3_w1_dout",   64'(b_dout),   64'hFFFF_FFFF);
        check("t3_w1_obits",  64'(b_obits),  64'd32);
        check("t3_w1_olast",  64'(b_olast),  64'h0);
      end
      if (k == 38) check("t3_mid", 64'(b_ovalid), 64'h0);
    end
    check("t3_w2_ovalid", 64'(b_ovalid), 64'h1);
    check("t3_w2_dout",   64'(b_dout),   64'h0000_00FF);
    check("t3_w2_obits",  64'(b_obits),  64'd8);
    check("t3_w2_olast",  64'(b_olast),  64'h1);
`ifdef BIN_POPCOUNT_EN
    check("t3_w2_opop",   64'(b_opop),   64'd8);
`endif
    ivalid = 1'b0;

    // backpressure: stalled word holds, input ignored
    do_reset();
    oready = 1'b0;
    for (int k = 0; k < 32; k++) beat(32'd1);
    check("t4_ovalid", 64'(a_ovalid), 64'h1);
    check("t4_iready", 64'(a_iready), 64'h0);
    for (int k = 0; k < 3; k++) begin
      beat(32'hFFFF_FFFF);
      check("t4_hold_ovalid", 64'(a_ovalid), 64'h1);
      check("t4_hold_dout",   64'(a_dout),   64'hFFFF_FFFF);
      check("t4_hold_iready", 64'(a_iready), 64'h0);
    end
    oready = 1'b1;
    #1;
    check("t4_release_iready", 64'(a_iready), 64'h1);
    @(posedge clk); #1;
    check("t4_after_hs", 64'(a_ovalid), 64'h0);
    for (int k = 0; k < 31; k++) beat(32'hFFFF_FFFF);
    check("t4_w2_ovalid", 64'(a_ovalid), 64'h1);
    check("t4_w2_dout",   64'(a_dout),   64'h0);
    check("t4_w2_olast",  64'(a_olast),  64'h1);
    ivalid = 1'b0;

    // mid-frame reset discards partial state
    do_reset();
    for (int k = 0; k < 10; k++) beat(32'hFFFF_FFFF);
    do_reset();
    for (int k = 0; k < 32; k++) begin
      beat(32'd7);
      if (k == 21 || k == 30) check("t5_early", 64'(a_ovalid), 64'h0);
    end
    check("t5_ovalid", 64'(a_ovalid), 64'h1);
    check("t5_dout",   64'(a_dout),   64'hFFFF_FFFF);
    check("t5_obits",  64'(a_obits),  64'd32);
    check("t5_olast",  64'(a_olast),  64'h0);
    ivalid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
